// File: rtl/xmit_pkg.sv
// Shared constants and types for the transmit priority scheduler.
// No logic; no latency.
// No flow control of its own.
package xmit_pkg;

    localparam int LEN_W_DEF         = 12;
    localparam int MAX_LEN_DEF       = 1518;
    localparam int IFG_CYCLES_DEF    = 12;
    localparam int LO_STARVE_MAX_DEF = 4;
    localparam int STARVE_W          = 3;

    // Source select as seen on tx_sel.
    localparam logic SEL_HI = 1'b0;
    localparam logic SEL_LO = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_GAP  = 2'd2,
        ST_DROP = 2'd3
    } sched_state_t;

endpackage

// File: rtl/xmit_starve_ctr.sv
// Saturating count of hi grants made while lo was waiting.
// Updates on the clock edge after inc/clr; at_max is a pure decode of the count.
// No backpressure; clr has priority over inc.
module xmit_starve_ctr #(
    parameter int W   = 3,
    parameter int MAX = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_max_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign at_max_o = (cnt_q == W'(MAX));

    // Next count: clear wins, increment stops at the ceiling.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !at_max_o) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/xmit_prio_sched.sv
// Picks hi/lo head frame, pops it one byte per cycle, then holds an inter-frame gap.
// First pop one cycle after the granting edge; frame lasts exactly L cycles.
// No grant while tx_busy; once a frame starts, tx_busy and queue changes are ignored.
module xmit_prio_sched
    import xmit_pkg::*;
#(
    parameter int LEN_W         = LEN_W_DEF,
    parameter int MAX_LEN       = MAX_LEN_DEF,
    parameter int IFG_CYCLES    = IFG_CYCLES_DEF,
    parameter int LO_STARVE_MAX = LO_STARVE_MAX_DEF
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             hi_frame_rdy,
    input  logic [LEN_W-1:0] hi_frame_len,
    input  logic             lo_frame_rdy,
    input  logic [LEN_W-1:0] lo_frame_len,
    input  logic             tx_busy,
    output logic             hi_rd_en,
    output logic             lo_rd_en,
    output logic             hi_frame_done,
    output logic             lo_frame_done,
    output logic             tx_valid,
    output logic             tx_sel,
    output logic             tx_sof,
    output logic             tx_eof,
    output logic             m_discard_en,
    output logic [1:0]       sched_state
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] GAP_LOAD  = LEN_W'(IFG_CYCLES - 1);

    sched_state_t     state_q, state_d;
    logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [LEN_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             sel_q, sel_d;
    logic             hi_rd_q, lo_rd_q, hi_done_q, lo_done_q;
    logic             valid_q, sof_q, eof_q, disc_q;
    logic             rd_d, sof_d, eof_d, done_d, disc_d;

    logic             starve_at_max;
    logic             pick_lo;
    logic [LEN_W-1:0] win_len;
    logic             len_bad;
    logic             arb_en;
    logic             grant;
    logic             starve_inc;
    logic             starve_clr;

    // Arbitration is also allowed on the edge closing the last gap cycle,
    // so back-to-back frames are separated by exactly IFG_CYCLES idle cycles.
    assign arb_en  = (state_q == ST_IDLE) || ((state_q == ST_GAP) && (gap_cnt_q == '0));
    assign grant   = arb_en && !tx_busy && (hi_frame_rdy || lo_frame_rdy);
    assign pick_lo = lo_frame_rdy && (!hi_frame_rdy || starve_at_max);
    assign win_len = pick_lo ? lo_frame_len : hi_frame_len;
    assign len_bad = (win_len == '0) || (win_len > MAX_LEN_L);

    // Dropped frames leave the fairness history untouched.
    assign starve_inc = grant && !len_bad && !pick_lo && lo_frame_rdy;
    assign starve_clr = grant && !len_bad && (pick_lo || !lo_frame_rdy);

    xmit_starve_ctr #(
        .W   (STARVE_W),
        .MAX (LO_STARVE_MAX)
    ) u_starve (
        .clk_i    (clk_sys),
        .rst_ni   (reset),
        .inc_i    (starve_inc),
        .clr_i    (starve_clr),
        .at_max_o (starve_at_max)
    );

    // Next state, counters and the strobes for the coming cycle.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        sel_d      = sel_q;
        rd_d       = 1'b0;
        sof_d      = 1'b0;
        eof_d      = 1'b0;
        done_d     = 1'b0;
        disc_d     = 1'b0;

        case (state_q)
            ST_XFER: begin
                if (byte_cnt_q == '0) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = GAP_LOAD;
                end else begin
                    byte_cnt_d = byte_cnt_q - LEN_W'(1);
                    rd_d       = 1'b1;
                    eof_d      = (byte_cnt_q == LEN_W'(1));
                    done_d     = (byte_cnt_q == LEN_W'(1));
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - LEN_W'(1);
                end
            end
            // Return through IDLE so the retired head entry is not re-sampled.
            ST_DROP: state_d = ST_IDLE;
            default: state_d = state_q;
        endcase

        if (grant) begin
            sel_d = pick_lo ? SEL_LO : SEL_HI;
            if (len_bad) begin
                state_d = ST_DROP;
                disc_d  = 1'b1;
                done_d  = 1'b1;
            end else begin
                state_d    = ST_XFER;
                byte_cnt_d = win_len - LEN_W'(1);
                rd_d       = 1'b1;
                sof_d      = 1'b1;
                eof_d      = (win_len == LEN_W'(1));
                done_d     = (win_len == LEN_W'(1));
            end
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            byte_cnt_q <= '0;
            gap_cnt_q  <= '0;
            sel_q      <= SEL_HI;
            hi_rd_q    <= 1'b0;
            lo_rd_q    <= 1'b0;
            hi_done_q  <= 1'b0;
            lo_done_q  <= 1'b0;
            valid_q    <= 1'b0;
            sof_q      <= 1'b0;
            eof_q      <= 1'b0;
            disc_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            sel_q      <= sel_d;
            hi_rd_q    <= rd_d && (sel_d == SEL_HI);
            lo_rd_q    <= rd_d && (sel_d == SEL_LO);
            hi_done_q  <= done_d && (sel_d == SEL_HI);
            lo_done_q  <= done_d && (sel_d == SEL_LO);
            valid_q    <= rd_d;
            sof_q      <= sof_d;
            eof_q      <= eof_d;
            disc_q     <= disc_d;
        end
    end

    assign hi_rd_en      = hi_rd_q;
    assign lo_rd_en      = lo_rd_q;
    assign hi_frame_done = hi_done_q;
    assign lo_frame_done = lo_done_q;
    assign tx_valid      = valid_q;
    assign tx_sel        = sel_q;
    assign tx_sof        = sof_q;
    assign tx_eof        = eof_q;
    assign m_discard_en  = disc_q;
    assign sched_state   = state_q;

endmodule

// File: tb/tb_xmit_prio_sched.sv
// Randomized and directed bench for xmit_prio_sched against a schedule-level model.
// Model plans whole frames ahead into a per-cycle expectation table.
// Queues are modelled as length lists popped on predicted frame_done.
module tb_xmit_prio_sched;

    localparam int LEN_W   = 12;
    localparam int MAX_LEN = 1518;
    localparam int IFG     = 12;
    localparam int SMAX    = 4;

    logic             clk_sys = 1'b0;
    logic             reset   = 1'b1;
    logic             hi_frame_rdy = 1'b0;
    logic [LEN_W-1:0] hi_frame_len = '0;
    logic             lo_frame_rdy = 1'b0;
    logic [LEN_W-1:0] lo_frame_len = '0;
    logic             tx_busy = 1'b0;
    logic             hi_rd_en, lo_rd_en, hi_frame_done, lo_frame_done;
    logic             tx_valid, tx_sel, tx_sof, tx_eof, m_discard_en;
    logic [1:0]       sched_state;

    xmit_prio_sched dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .hi_frame_rdy  (hi_frame_rdy),
        .hi_frame_len  (hi_frame_len),
        .lo_frame_rdy  (lo_frame_rdy),
        .lo_frame_len  (lo_frame_len),
        .tx_busy       (tx_busy),
        .hi_rd_en      (hi_rd_en),
        .lo_rd_en      (lo_rd_en),
        .hi_frame_done (hi_frame_done),
        .lo_frame_done (lo_frame_done),
        .tx_valid      (tx_valid),
        .tx_sel        (tx_sel),
        .tx_sof        (tx_sof),
        .tx_eof        (tx_eof),
        .m_discard_en  (m_discard_en),
        .sched_state   (sched_state)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct packed {
        logic       hi_rd;
        logic       lo_rd;
        logic       hi_done;
        logic       lo_done;
        logic       valid;
        logic       sel;
        logic       sof;
        logic       eof;
        logic       disc;
        logic [1:0] st;
    } obs_t;

    obs_t             exp_mem [int];
    logic [LEN_W-1:0] hiq[$];
    logic [LEN_W-1:0] loq[$];
    int               sof_log[$];
    int               sof_cyc[$];
    int               eof_cyc[$];
    int               cyc = 0;
    int               free_at = 0;
    int               starve = 0;
    bit               busy = 1'b0;
    int               hi_rd_seen = 0;
    int               disc_seen = 0;
    int               n_chk = 0;
    int               n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, got, want);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.hi_rd   = hi_rd_en;
        o.lo_rd   = lo_rd_en;
        o.hi_done = hi_frame_done;
        o.lo_done = lo_frame_done;
        o.valid   = tx_valid;
        o.sel     = (tx_valid || m_discard_en) ? tx_sel : 1'b0;
        o.sof     = tx_sof;
        o.eof     = tx_eof;
        o.disc    = m_discard_en;
        o.st      = sched_state;
        return o;
    endfunction

    // Plan the whole outcome of a grant at the edge closing cycle 'cyc'.
    task automatic model_edge();
        bit   pick_lo;
        int   len;
        obs_t e;
        if (cyc < free_at || busy || (hiq.size() == 0 && loq.size() == 0)) return;
        pick_lo = (loq.size() > 0) && (hiq.size() == 0 || starve == SMAX);
        len = pick_lo ? int'(loq[0]) : int'(hiq[0]);
        if (len == 0 || len > MAX_LEN) begin
            e = '0;
            e.disc = 1'b1; e.sel = pick_lo; e.hi_done = !pick_lo; e.lo_done = pick_lo; e.st = 2'd3;
            exp_mem[cyc + 1] = e;
            free_at = cyc + 2;
        end else begin
            for (int i = 1; i <= len; i++) begin
                e = '0;
                e.hi_rd = !pick_lo; e.lo_rd = pick_lo; e.valid = 1'b1; e.sel = pick_lo;
                e.sof = (i == 1); e.eof = (i == len);
                e.hi_done = (i == len) && !pick_lo; e.lo_done = (i == len) && pick_lo;
                e.st = 2'd1;
                exp_mem[cyc + i] = e;
            end
            for (int g = 1; g <= IFG; g++) begin
                e = '0;
                e.st = 2'd2;
                exp_mem[cyc + len + g] = e;
            end
            free_at = cyc + len + IFG;
            if (pick_lo || loq.size() == 0) starve = 0;
            else if (starve < SMAX) starve = starve + 1;
        end
    endtask

    task automatic run_cycle();
        obs_t e;
        obs_t o;
        hi_frame_rdy = (hiq.size() > 0);
        hi_frame_len = (hiq.size() > 0) ? hiq[0] : LEN_W'($urandom);
        lo_frame_rdy = (loq.size() > 0);
        lo_frame_len = (loq.size() > 0) ? loq[0] : LEN_W'($urandom);
        tx_busy      = busy;
        if (reset) model_edge();
        @(posedge clk_sys);
        @(negedge clk_sys);
        cyc++;
        e = exp_mem.exists(cyc) ? exp_mem[cyc] : obs_t'(0);
        o = sample();
        check("outs", 32'(o), 32'(e));
        check("rd_excl", {31'd0, hi_rd_en & lo_rd_en}, 32'd0);
        if (tx_sof) begin
            sof_log.push_back(int'(tx_sel));
            sof_cyc.push_back(cyc);
        end
        if (tx_eof) eof_cyc.push_back(cyc);
        if (hi_rd_en) hi_rd_seen++;
        if (m_discard_en) disc_seen++;
        if (e.hi_done && hiq.size() > 0) hiq.delete(0);
        if (e.lo_done && loq.size() > 0) loq.delete(0);
        exp_mem.delete(cyc);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        busy = 1'b0;
        while ((hiq.size() > 0 || loq.size() > 0 || cyc <= free_at) && n < budget) begin
            run_cycle();
            n++;
        end
        check("drain", hiq.size() + loq.size(), 32'd0);
    endtask

    function automatic logic [LEN_W-1:0] rand_len();
        int r;
        r = $urandom_range(0, 31);
        case (r)
            0:       return LEN_W'(0);
            1:       return LEN_W'(MAX_LEN + 1);
            2:       return LEN_W'(MAX_LEN);
            3:       return LEN_W'(2000);
            default: return LEN_W'($urandom_range(1, 24));
        endcase
    endfunction

    initial begin
        int exp_b[10];
        int exp_g[9];
        int base;
        exp_b = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        exp_g = '{0, 0, 0, 0, 1, 0, 0, 0, 1};

        // Reset held: every output must read zero.
        #2 reset = 1'b0;
        @(negedge clk_sys);
        repeat (4) run_cycle();
        reset = 1'b1;

        // Hi only, 64-byte frames, gap spacing.
        sof_cyc.delete();
        eof_cyc.delete();
        repeat (3) hiq.push_back(LEN_W'(64));
        drain(2000);
        check("A_sofs", sof_cyc.size(), 32'd3);
        if (sof_cyc.size() >= 2 && eof_cyc.size() >= 1)
            check("A_gap", sof_cyc[1] - eof_cyc[0], IFG + 1);

        // Both queues loaded: lo forced every fifth grant.
        sof_log.delete();
        for (int i = 0; i < 10; i++) begin
            hiq.push_back(LEN_W'(64));
            loq.push_back(LEN_W'(64));
        end
        drain(5000);
        check("B_cnt", sof_log.size(), 32'd20);
        for (int i = 0; i < 10 && i < sof_log.size(); i++)
            check("B_order", sof_log[i], exp_b[i]);

        // Downstream busy holds off the grant.
        busy = 1'b1;
        base = hi_rd_seen;
        hiq.push_back(LEN_W'(64));
        repeat (10) run_cycle();
        check("C_noread", hi_rd_seen - base, 32'd0);
        drain(500);

        // Zero and oversize lengths dropped, then a one-byte frame.
        base = disc_seen;
        hiq.push_back(LEN_W'(0));
        hiq.push_back(LEN_W'(2000));
        hiq.push_back(LEN_W'(1));
        drain(200);
        check("D_disc", disc_seen - base, 32'd2);

        // Starvation release, then counter back at zero.
        sof_log.delete();
        repeat (6) hiq.push_back(LEN_W'(4));
        loq.push_back(LEN_W'(4));
        drain(500);
        hiq.push_back(LEN_W'(3));
        loq.push_back(LEN_W'(3));
        drain(200);
        check("G_cnt", sof_log.size(), 32'd9);
        for (int i = 0; i < 9 && i < sof_log.size(); i++)
            check("G_order", sof_log[i], exp_g[i]);

        // Random traffic with busy noise.
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 15) == 0) hiq.push_back(rand_len());
            if ($urandom_range(0, 15) == 0) loq.push_back(rand_len());
            busy = ($urandom_range(0, 3) == 0);
            run_cycle();
        end
        drain(30000);

        // Reset in the middle of a frame, then a fresh full frame.
        base = hi_rd_seen;
        hiq.push_back(LEN_W'(64));
        for (int n = 0; n < 300 && (hi_rd_seen - base) < 30; n++) run_cycle();
        check("F_byte30", hi_rd_seen - base, 32'd30);
        reset = 1'b0;
        exp_mem.delete();
        free_at = 0;
        starve  = 0;
        run_cycle();
        check("F_state", {30'd0, sched_state}, 32'd0);
        reset = 1'b1;
        base = hi_rd_seen;
        drain(300);
        check("F_refill", hi_rd_seen - base, 32'd64);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/xmit_prio_sched.md
Name: xmit_prio_sched

Overview:
Frame-level scheduler between the high- and low-priority transmit queues in the Xmit path, running on clk_sys. It chooses which queue's head frame goes to the PHY-side converter next and pops that frame one byte per cycle for its full length. It enforces an inter-frame gap and gives bounded service to the low-priority queue. Length fields come from the control-block path (64-byte frames nominal).

Parameters:
LEN_W, 12, width of frame length field (bytes)
MAX_LEN, 1518, largest legal frame length; longer frames are discarded
IFG_CYCLES, 12, idle clk_sys cycles enforced after every transmitted frame
LO_STARVE_MAX, 4, consecutive hi grants with lo pending before lo is forced

Ports:
clk_sys  in  1  system clock; all logic on its rising edge
reset  in  1  asynchronous, active-low reset
hi_frame_rdy  in  1  hi queue holds at least one complete frame
hi_frame_len  in  LEN_W  head hi frame length; valid while hi_frame_rdy
lo_frame_rdy  in  1  lo queue holds at least one complete frame
lo_frame_len  in  LEN_W  head lo frame length; valid while lo_frame_rdy
tx_busy  in  1  downstream converter cannot start a new frame
hi_rd_en  out  1  pop one byte from hi data queue
lo_rd_en  out  1  pop one byte from lo data queue
hi_frame_done  out  1  one-cycle pulse; retire hi head control entry
lo_frame_done  out  1  one-cycle pulse; retire lo head control entry
tx_valid  out  1  byte popped this cycle is forwarded downstream
tx_sel  out  1  0 = hi source, 1 = lo source; held for the whole frame
tx_sof  out  1  first byte of frame
tx_eof  out  1  last byte of frame
m_discard_en  out  1  one-cycle pulse; head frame dropped for bad length
sched_state  out  2  current FSM state (debug)

Behaviour:
- All outputs are registered. While reset=0: every output is 0, FSM=IDLE, byte counter=0, gap counter=0, starve counter=0.
- FSM encoding: IDLE=0, XFER=1, GAP=2, DROP=3.
- IDLE: arbitrate on every edge where tx_busy=0 and (hi_frame_rdy or lo_frame_rdy).
  - Winner is lo if lo_frame_rdy and (!hi_frame_rdy or starve_cnt==LO_STARVE_MAX); otherwise hi.
  - Winner length L is latched and tx_sel is set.
  - L==0 or L>MAX_LEN: go to DROP.
  - Otherwise: go to XFER with counter=L-1.
- XFER: one byte per cycle.
  - Selected rd_en=1 and tx_valid=1 every cycle.
  - tx_sof=1 on the first cycle only.
  - On the cycle counter reaches 0: tx_eof=1 and the selected frame_done pulses. Next state is GAP.
  - For L=1, sof, eof and frame_done share one cycle.
  - Latency: rdy sampled at edge N gives the first rd_en in cycle N+1 (the cycle after edge N). Frame occupies exactly L cycles.
  - rdy/len/tx_busy changes during XFER are ignored.
- GAP: all strobes 0 for exactly IFG_CYCLES cycles, then IDLE. The next grant is earliest at the edge ending the last GAP cycle, so back-to-back frames have the first rd_en of the next frame IFG_CYCLES+1 cycles after eof.
- DROP: for one cycle, m_discard_en=1 and the selected frame_done=1, with no rd_en and no tx_valid. Then IDLE with no gap. A dropped frame does not change starve_cnt.
- Starvation counter (3 bits, saturates at LO_STARVE_MAX):
  - Increments on a hi grant while lo_frame_rdy=1.
  - Clears on any lo grant.
  - Clears on a hi grant with lo_frame_rdy=0.
- Counters use LEN_W bits; no wrap is possible because L≤MAX_LEN<2^LEN_W.
- hi_rd_en and lo_rd_en are never both 1. At most one frame_done pulses per cycle.
- Reset asserted mid-frame aborts immediately; every output is 0 on the next cycle. Flushing the partial frame belongs to the queue owners.

Decomposition:
- Shared package xmit_pkg: state encoding constants, SEL_HI/SEL_LO, LEN_W, MAX_LEN default.
- One sub-module: xmit_starve_ctr (saturating counter with inc/clr inputs and an at_max output).
- Arbitration and FSM stay in xmit_prio_sched.

Test Plan:
- Hi only, len=64, tx_busy=0: hi_rd_en high for exactly 64 cycles; sof on cycle 1; eof and hi_frame_done on cycle 64; next sof 13 cycles after eof.
- Both rdy continuously, len=64: grant order hi,hi,hi,hi,lo,hi,hi,hi,hi,lo; lo_rd_en and hi_rd_en never both 1.
- tx_busy=1 with hi_rdy=1 for 10 cycles: no rd_en. Release tx_busy: first hi_rd_en on the following cycle.
- hi_len=0, then hi_len=2000, then hi_len=1: two DROP cycles, each with m_discard_en=1 and hi_frame_done=1 and no reads. Then a single cycle with sof=eof=done=1.
- Drop reset low at byte 30 of a 64-byte frame: all outputs 0 next cycle; sched_state=0. After release, a fresh full 64-byte frame starts from sof.
- lo_rdy rises during a hi frame with starve_cnt=4: the next grant goes to lo, and starve_cnt reads 0 afterward.
